fp_mul_arb: RTL and testbench

FP_MUL_ARB -- requirements
Module: fp_mul_arb

---
 rtl/fp_arb_pkg.sv | 15 +
 rtl/fp_mul_arb_rr_arbiter.sv | 44 ++++
 rtl/fp_mul_arb.sv | 108 ++++++++++
 tb/tb_fp_mul_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// Shared constants and tag payload for the fp_mul sharing arbiter.
package fp_arb_pkg;

    localparam int unsigned FP_W        = 32;
    localparam int unsigned MUL_LAT_DEF = 5;
    localparam int unsigned N_REQ_MAX   = 8;
    // Sized for the largest supported requester count so one typedef serves every N_REQ.
    localparam int unsigned TAG_IDX_W   = $clog2(N_REQ_MAX);

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/fp_mul_arb_rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module rr_arbiter #(
    parameter  int unsigned N     = 2,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_any
);

    logic [IDX_W-1:0] r_ptr;
    int unsigned      w_pos;

    // First requester at or above the pointer wins, wrapping past N-1; nothing granted in reset.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        w_pos       = 0;
        if (!areset) begin
            for (int unsigned off = 0; off < N; off++) begin
                w_pos = (32'(r_ptr) + off) % N;
                if (!o_grant_any && i_req[IDX_W'(w_pos)]) begin
                    o_grant[IDX_W'(w_pos)] = 1'b1;
                    o_grant_idx            = IDX_W'(w_pos);
                    o_grant_any            = 1'b1;
                end
            end
        end
    end

    // Pointer moves to the slot after the winner; holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (areset) begin
            r_ptr <= '0;
        end else if (o_grant_any) begin
            r_ptr <= (32'(o_grant_idx) == N - 1) ? '0 : o_grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/fp_mul_arb.sv
// Shares one external pipelined fp_mul among N_REQ requesters; results are routed back by tag.
module fp_mul_arb
    import fp_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [FP_W*N_REQ-1:0] req_a,
    input  logic [FP_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]       rsp_q,
    output logic                  busy,
    output logic                  mul_en,
    output logic [FP_W-1:0]       mul_a,
    output logic [FP_W-1:0]       mul_b,
    input  logic [FP_W-1:0]       mul_q
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned DEPTH = MUL_LAT + 1;

    logic [IDX_W-1:0] w_grant_idx;
    logic             w_grant_any;
    logic [FP_W-1:0]  r_mul_a;
    logic [FP_W-1:0]  r_mul_b;
    logic             r_mul_en;
    tag_t             r_tag [DEPTH];
    tag_t             w_tag_in;
    tag_t             w_tag_out;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk         (clk),
        .areset      (areset),
        .i_req       (req_valid),
        .o_grant     (req_ready),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    // Capture the winner's operands; the multiplier pipeline runs freely once out of reset.
    always_ff @(posedge clk) begin
        if (areset) begin
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_mul_en <= 1'b0;
        end else begin
            r_mul_en <= 1'b1;
            if (w_grant_any) begin
                r_mul_a <= req_a[32'(w_grant_idx)*FP_W +: FP_W];
                r_mul_b <= req_b[32'(w_grant_idx)*FP_W +: FP_W];
            end
        end
    end

    // Tag entering the pipeline alongside the captured operands.
    always_comb begin
        w_tag_in       = '0;
        w_tag_in.valid = w_grant_any;
        w_tag_in.idx   = TAG_IDX_W'(w_grant_idx);
    end

    // Tag shift register; its last stage lines up with mul_q for the same operands.
    always_ff @(posedge clk) begin
        if (areset) begin
            for (int unsigned d = 0; d < DEPTH; d++) begin
                r_tag[d] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int unsigned d = 1; d < DEPTH; d++) begin
                r_tag[d] <= r_tag[d-1];
            end
        end
    end

    assign w_tag_out = r_tag[DEPTH-1];

    // Route the emerging product to its owner; busy reflects any tag still in flight.
    always_comb begin
        rsp_valid = '0;
        rsp_q     = '0;
        busy      = 1'b0;
        if (!areset) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (w_tag_out.valid && (w_tag_out.idx == TAG_IDX_W'(i))) begin
                    rsp_valid[i] = 1'b1;
                end
            end
            if (w_tag_out.valid) begin
                rsp_q = mul_q;
            end
            for (int unsigned d = 0; d < DEPTH; d++) begin
                busy = busy | r_tag[d].valid;
            end
        end
    end

    assign mul_a  = r_mul_a;
    assign mul_b  = r_mul_b;
    assign mul_en = r_mul_en;

endmodule

// File: tb/tb_fp_mul_arb.sv
// Bench for fp_mul_arb: behavioural fp_mul, round-robin reference and in-order response scoreboard.
module tb_fp_mul_arb;

    localparam int unsigned N_REQ   = 2;
    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned W       = 32;

    logic                  clk = 1'b0;
    logic                  areset;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*W-1:0]    req_a;
    logic [N_REQ*W-1:0]    req_b;
    logic [N_REQ-1:0]      rsp_valid;
    logic [W-1:0]          rsp_q;
    logic                  busy;
    logic                  mul_en;
    logic [W-1:0]          mul_a;
    logic [W-1:0]          mul_b;
    logic [W-1:0]          mul_q;

    int checks = 0;
    int errors = 0;

    fp_mul_arb #(
        .N_REQ   (N_REQ),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_q     (rsp_q),
        .busy      (busy),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_q     (mul_q)
    );

    always #5 clk = ~clk;

    // Single-precision <-> real for normal numbers and zero (all bench operands are such values).
    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) d = {b[31], 63'd0};
        else d = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) * sp2r(b));
    endfunction

    // Behavioural fp_mul: MUL_LAT register stages advancing while mul_en is high.
    logic [W-1:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        if (mul_en) begin
            mpipe[0] <= fmul(mul_a, mul_b);
            for (int i = 1; i < int'(MUL_LAT); i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_q = mpipe[MUL_LAT-1];

    // Operands whose pairwise products are exact in single precision.
    logic [31:0] op_tab [12] = '{32'h00000000, 32'h3F000000, 32'h3F800000, 32'h3FC00000,
                                 32'h40000000, 32'h40400000, 32'h40A00000, 32'h41000000,
                                 32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hBFC00000};

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] prod;
    } exp_t;

    exp_t        sb[$];
    int          cyc;
    int          ptr;
    logic        cur_rst;
    logic        last_edge_rst;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [N_REQ-1:0] obs_rv;
    logic [N_REQ-1:0] obs_rdy;
    logic [31:0]      obs_q;
    logic             obs_busy;
    logic [N_REQ-1:0] rv_hist   [16];
    logic [31:0]      q_hist    [16];
    logic             busy_hist [16];
    logic [N_REQ-1:0] grant_hist [4];
    int               pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic [N_REQ*W-1:0] pk(input logic [31:0] x0, input logic [31:0] x1);
        return {x1, x0};
    endfunction

    // One clock of stimulus: check outputs of the current cycle, drive new inputs, check grant.
    task automatic step(input logic rst, input logic [N_REQ-1:0] v,
                        input logic [N_REQ*W-1:0] a, input logic [N_REQ*W-1:0] b);
        logic [N_REQ-1:0] e_rv;
        logic [N_REQ-1:0] e_rdy;
        logic [31:0]      e_q;
        logic             e_busy;
        int               g;
        int               j;
        @(negedge clk);
        e_rv = '0; e_q = '0; e_busy = 1'b0;
        if (!cur_rst && sb.size() != 0) begin
            e_busy = 1'b1;
            if (sb[0].due == cyc) begin
                e_rv[sb[0].idx] = 1'b1;
                e_q = sb[0].prod;
                void'(sb.pop_front());
            end
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("rsp_q", rsp_q, e_q);
        chk("busy", 32'(busy), 32'(e_busy));
        chk("mul_en", 32'(mul_en), 32'(!last_edge_rst));
        chk("mul_a", mul_a, exp_a);
        chk("mul_b", mul_b, exp_b);
        obs_rv = rsp_valid; obs_q = rsp_q; obs_busy = busy;

        areset = rst; req_valid = v; req_a = a; req_b = b;
        #1;
        e_rdy = '0; g = -1;
        if (!rst) begin
            for (int k = 0; k < int'(N_REQ); k++) begin
                j = (ptr + k) % int'(N_REQ);
                if (g < 0 && v[j]) g = j;
            end
        end
        if (g >= 0) e_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        obs_rdy = req_ready;

        if (rst) begin
            sb.delete(); ptr = 0; exp_a = '0; exp_b = '0;
        end else if (g >= 0) begin
            sb.push_back('{due: cyc + 1 + int'(MUL_LAT), idx: g,
                           prod: fmul(a[g*W +: W], b[g*W +: W])});
            ptr   = (g + 1) % int'(N_REQ);
            exp_a = a[g*W +: W];
            exp_b = b[g*W +: W];
        end
        cur_rst = rst; last_edge_rst = rst;
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, '0, '0, '0);
            rv_hist[i] = obs_rv; q_hist[i] = obs_q; busy_hist[i] = obs_busy;
        end
    endtask

    initial begin
        logic [N_REQ*W-1:0] ra;
        logic [N_REQ*W-1:0] rb;
        logic               rr;

        areset = 1'b1; req_valid = '1; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mul_en", 32'(mul_en), 32'd0);
        chk("reset_mul_a", mul_a, 32'd0);
        chk("reset_mul_b", mul_b, 32'd0);
        cur_rst = 1'b1; last_edge_rst = 1'b1; ptr = 0; cyc = 0; exp_a = '0; exp_b = '0;

        // Both requesters contend for four cycles starting in the first cycle out of reset.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b11, pk(32'h3F800000, 32'hC0000000), pk(32'h3F800000, 32'h40400000));
            grant_hist[i] = obs_rdy;
        end
        chk("alt_grant0", 32'(grant_hist[0]), 32'h1);
        chk("alt_grant1", 32'(grant_hist[1]), 32'h2);
        chk("alt_grant2", 32'(grant_hist[2]), 32'h1);
        chk("alt_grant3", 32'(grant_hist[3]), 32'h2);
        idle(10);
        chk("alt_rsp0_valid", 32'(rv_hist[2]), 32'h1);
        chk("alt_rsp0_q", q_hist[2], 32'h3F800000);
        chk("alt_rsp1_valid", 32'(rv_hist[3]), 32'h2);
        chk("alt_rsp1_q", q_hist[3], 32'hC0C00000);
        chk("alt_rsp2_valid", 32'(rv_hist[4]), 32'h1);
        chk("alt_rsp3_valid", 32'(rv_hist[5]), 32'h2);
        chk("alt_rsp3_q", q_hist[5], 32'hC0C00000);

        // Single product 2.0 x 3.0 from requester 0.
        step(1'b0, 2'b01, pk(32'h40000000, 32'h0), pk(32'h40400000, 32'h0));
        chk("single_grant", 32'(obs_rdy), 32'h1);
        idle(8);
        chk("single_early", 32'(rv_hist[4]), 32'h0);
        chk("single_valid", 32'(rv_hist[5]), 32'h1);
        chk("single_q", q_hist[5], 32'h40C00000);
        chk("single_late", 32'(rv_hist[6]), 32'h0);

        // Requester 1 alone, three back-to-back zero products.
        for (int i = 0; i < 3; i++) step(1'b0, 2'b10, pk(32'h0, 32'h00000000), pk(32'h0, 32'h40A00000));
        idle(10);
        chk("b2b_rsp0", 32'(rv_hist[3]), 32'h2);
        chk("b2b_rsp1", 32'(rv_hist[4]), 32'h2);
        chk("b2b_rsp2", 32'(rv_hist[5]), 32'h2);
        chk("b2b_q2", q_hist[5], 32'h0);
        chk("b2b_busy_last", 32'(busy_hist[5]), 32'h1);
        chk("b2b_busy_after", 32'(busy_hist[6]), 32'h0);

        // Reset while three products are in flight, then an immediate new request.
        for (int i = 0; i < 3; i++) step(1'b0, 2'b11, pk(32'h40000000, 32'h40400000), pk(32'h40000000, 32'h40400000));
        step(1'b1, 2'b11, pk(32'h40000000, 32'h40400000), pk(32'h40000000, 32'h40400000));
        chk("rst_mid_ready", 32'(obs_rdy), 32'h0);
        step(1'b0, 2'b01, pk(32'h3FC00000, 32'h0), pk(32'h40000000, 32'h0));
        chk("post_rst_grant", 32'(obs_rdy), 32'h1);
        idle(12);
        pulses = 0;
        for (int i = 0; i < 12; i++) if (rv_hist[i] != '0) pulses++;
        chk("post_rst_pulses", 32'(pulses), 32'd1);

        // Random traffic with random valids, drops and occasional resets.
        for (int n = 0; n < 1000; n++) begin
            for (int r = 0; r < int'(N_REQ); r++) begin
                ra[r*W +: W] = op_tab[$urandom_range(11)];
                rb[r*W +: W] = op_tab[$urandom_range(11)];
            end
            rr = ($urandom_range(199) == 0);
            step(rr, N_REQ'($urandom), ra, rb);
        end
        idle(MUL_LAT + 4);
        chk("drain_all", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
